// File: rtl/mpi_credit_endpoint.sv
// Credit-based MPI endpoint: a sender that streams sequence-numbered words
// while it holds credits, and an independent receiver that returns credits.
module mpi_credit_endpoint #(
  parameter int unsigned CREDITS = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] rank_i,
  input  logic [31:0] dest_i,
  input  logic        tx_yummy_i,
  output logic        tx_valid_o,
  output logic [63:0] tx_data_o,
  output logic [7:0]  tx_credit_o,
  input  logic        rx_valid_i,
  input  logic [63:0] rx_data_i,
  output logic [63:0] rx_data_o,
  output logic        rx_yummy_o,
  output logic [31:0] rx_count_o
);

  localparam logic [7:0] CREDIT_MAX = 8'(CREDITS);

  logic [7:0]  credit;
  logic [7:0]  credit_next;
  logic [31:0] seq;
  logic        tx_valid;
  logic        rx_yummy;
  logic [63:0] rx_data;
  logic [31:0] rx_count;
  logic        unused_rank_bits;

  assign unused_rank_bits = ^{rank_i[31:16], dest_i[31:16]};

  // A send with a simultaneous return is a wash; returns beyond the cap are dropped.
  always_comb begin
    credit_next = credit;
    if (tx_valid && !tx_yummy_i) begin
      credit_next = credit - 8'd1;
    end else if (!tx_valid && tx_yummy_i && (credit != CREDIT_MAX)) begin
      credit_next = credit + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      credit   <= CREDIT_MAX;
      tx_valid <= 1'b0;
      seq      <= 32'd0;
    end else begin
      credit   <= credit_next;
      tx_valid <= (credit_next != 8'd0);
      if (tx_valid) begin
        seq <= seq + 32'd1;
      end
    end
  end

  // The word is built from seq, so it only moves when a transfer advances seq.
  assign tx_data_o   = {rank_i[15:0], dest_i[15:0], seq};
  assign tx_valid_o  = tx_valid;
  assign tx_credit_o = credit;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rx_yummy <= 1'b0;
      rx_data  <= 64'd0;
      rx_count <= 32'd0;
    end else begin
      rx_yummy <= rx_valid_i;
      if (rx_valid_i) begin
        rx_data  <= rx_data_i;
        rx_count <= rx_count + 32'd1;
      end
    end
  end

  assign rx_yummy_o = rx_yummy;
  assign rx_data_o  = rx_data;
  assign rx_count_o = rx_count;

endmodule

// File: tb/tb_mpi_credit_endpoint.sv
// Randomised scoreboard bench for mpi_credit_endpoint: a credit/sequence
// reference model feeds expected words into queues that a monitor drains.
module tb_mpi_credit_endpoint;

  localparam int CREDITS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] rank = 32'd1;
  logic [31:0] dest = 32'd2;
  logic        yummy = 1'b0;
  logic        rx_valid = 1'b0;
  logic [63:0] rx_data = 64'd0;

  logic        tx_valid_o;
  logic [63:0] tx_data_o;
  logic [7:0]  tx_credit_o;
  logic [63:0] rx_data_o;
  logic        rx_yummy_o;
  logic [31:0] rx_count_o;

  int n_cmp = 0;
  int n_fail = 0;

  int          m_credit;
  bit          m_valid;
  int unsigned m_seq_next;
  bit          m_yummy;
  int unsigned m_count;
  logic [63:0] tx_q[$];
  logic [63:0] rx_q[$];

  mpi_credit_endpoint #(.CREDITS(CREDITS)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .rank_i     (rank),
    .dest_i     (dest),
    .tx_yummy_i (yummy),
    .tx_valid_o (tx_valid_o),
    .tx_data_o  (tx_data_o),
    .tx_credit_o(tx_credit_o),
    .rx_valid_i (rx_valid),
    .rx_data_i  (rx_data),
    .rx_data_o  (rx_data_o),
    .rx_yummy_o (rx_yummy_o),
    .rx_count_o (rx_count_o)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_credit   = CREDITS;
    m_valid    = 1'b0;
    m_seq_next = 0;
    m_yummy    = 1'b0;
    m_count    = 0;
    tx_q.delete();
    rx_q.delete();
  endtask

  // Reference: credit = min(CREDITS, credit - sent + returned); a word goes out
  // every cycle the credit pool is non-empty, numbered consecutively.
  always @(posedge clk) begin
    if (!rst) begin
      m_credit = m_credit - (m_valid ? 1 : 0) + (yummy ? 1 : 0);
      if (m_credit > CREDITS) m_credit = CREDITS;
      m_valid = (m_credit != 0);
      if (m_valid) begin
        tx_q.push_back({rank[15:0], dest[15:0], m_seq_next[31:0]});
        m_seq_next++;
      end
      m_yummy = rx_valid;
      if (rx_valid) begin
        rx_q.push_back(rx_data);
        m_count++;
      end
    end
  end

  always @(negedge clk) begin
    check_output("tx_valid", 64'(tx_valid_o), 64'(m_valid));
    check_output("tx_credit", 64'(tx_credit_o), 64'(m_credit));
    if (tx_valid_o === 1'b1) begin
      if (tx_q.size() == 0) begin
        check_output("tx_word_unexpected", tx_data_o, 64'hx);
      end else begin
        check_output("tx_data", tx_data_o, tx_q.pop_front());
      end
    end
    check_output("rx_yummy", 64'(rx_yummy_o), 64'(m_yummy));
    if (rx_yummy_o === 1'b1) begin
      if (rx_q.size() == 0) begin
        check_output("rx_word_unexpected", rx_data_o, 64'hx);
      end else begin
        check_output("rx_data", rx_data_o, rx_q.pop_front());
      end
    end
    check_output("rx_count", 64'(rx_count_o), 64'(m_count));
  end

  task automatic apply_stimulus(input logic y, input logic rv, input logic [63:0] rd);
    @(posedge clk);
    #1;
    yummy    = y;
    rx_valid = rv;
    rx_data  = rd;
  endtask

  task automatic check_reset_values();
    check_output("rst_tx_valid", 64'(tx_valid_o), 64'd0);
    check_output("rst_tx_credit", 64'(tx_credit_o), 64'(CREDITS));
    check_output("rst_tx_data", tx_data_o, {rank[15:0], dest[15:0], 32'h0});
    check_output("rst_rx_data", rx_data_o, 64'd0);
    check_output("rst_rx_count", 64'(rx_count_o), 64'd0);
    check_output("rst_rx_yummy", 64'(rx_yummy_o), 64'd0);
  endtask

  // Assert reset mid-cycle and check outputs before any clock edge.
  task automatic do_reset(input logic y_at_release);
    @(negedge clk);
    #2;
    rst      = 1'b1;
    yummy    = 1'b0;
    rx_valid = 1'b0;
    rank     = $urandom;
    dest     = $urandom;
    model_reset();
    #1;
    check_reset_values();
    repeat (2) @(posedge clk);
    #1;
    yummy = y_at_release;
    rst   = 1'b0;
  endtask

  initial begin
    model_reset();
    #2;
    rst = 1'b1;
    #1;
    check_reset_values();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Four credits, no returns: exactly four words then silence.
    repeat (10) apply_stimulus(1'b0, 1'b0, 64'd0);
    // One returned credit buys one more word.
    apply_stimulus(1'b1, 1'b0, 64'd0);
    repeat (5) apply_stimulus(1'b0, 1'b0, 64'd0);

    apply_stimulus(1'b0, 1'b1, 64'hA);
    apply_stimulus(1'b0, 1'b1, 64'hB);
    apply_stimulus(1'b0, 1'b1, 64'hC);
    repeat (3) apply_stimulus(1'b0, 1'b0, 64'd0);
    @(negedge clk);
    #1;
    check_output("rx_last_word", rx_data_o, 64'hC);
    check_output("rx_total", 64'(rx_count_o), 64'd5 - 64'd2);

    // Return arriving at full credit with nothing in flight, then a steady stream.
    do_reset(1'b1);
    repeat (20) apply_stimulus(1'b1, 1'b0, 64'd0);

    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        apply_stimulus(1'b0, 1'b1, {$urandom, $urandom});
        do_reset(1'b0);
      end
      apply_stimulus($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 50, {$urandom, $urandom});
    end

    apply_stimulus(1'b0, 1'b0, 64'd0);
    @(negedge clk);
    #1;
    check_output("tx_queue_drained", 64'(tx_q.size()), 64'd0);
    check_output("rx_queue_drained", 64'(rx_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mpi_credit_endpoint.md
MPI_CREDIT_ENDPOINT -- requirements
Module: mpi_credit_endpoint

Interface
REQ-001 SHALL have parameter CREDITS, default 4: sender credit count after reset; legal range 1..255.
REQ-002 SHALL have port clk_i, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port rank_i, input, 32 bits: this node's rank; quasi-static.
REQ-005 SHALL have port dest_i, input, 32 bits: destination rank; quasi-static.
REQ-006 SHALL have port tx_yummy_i, input, 1 bit: credit return; one pulse returns one credit.
REQ-007 SHALL have port tx_valid_o, output, 1 bit: tx_data_o holds a word that transfers this cycle.
REQ-008 SHALL have port tx_data_o, output, 64 bits: outgoing word.
REQ-009 SHALL have port tx_credit_o, output, 8 bits: current sender credit count.
REQ-010 SHALL have port rx_valid_i, input, 1 bit: rx_data_i holds a word this cycle.
REQ-011 SHALL have port rx_data_i, input, 64 bits: incoming word.
REQ-012 SHALL have port rx_data_o, output, 64 bits: last accepted incoming word.
REQ-013 SHALL have port rx_yummy_o, output, 1 bit: credit return to the remote sender.
REQ-014 SHALL have port rx_count_o, output, 32 bits: number of words accepted since reset.

Function
REQ-015 Sender and receiver paths SHALL be independent and SHALL share only clk_i and rst_i.
REQ-016 Sender word format SHALL be {rank_i[15:0], dest_i[15:0], seq[31:0]}; seq is an internal counter.
REQ-017 A transfer SHALL occur on every rising edge where tx_valid_o=1; no ready signal exists.
REQ-018 Credit update per edge, with t = tx_valid_o and y = tx_yummy_i:
- t=1, y=0: credit -1.
- t=0, y=1: credit +1.
- t=1, y=1: credit unchanged.
- t=0, y=0: credit unchanged.
REQ-019 Credit SHALL saturate at CREDITS; a yummy arriving at CREDITS with t=0 is ignored.
REQ-020 Credit SHALL never underflow; this is guaranteed by REQ-021.
REQ-021 tx_valid_o SHALL be registered, with next value = (next credit != 0).
REQ-022 On each transfer, seq SHALL increment by 1, wrapping 0xFFFFFFFF->0, and tx_data_o SHALL update to the word carrying the new seq.
REQ-023 tx_data_o SHALL hold its value while tx_valid_o=0.
REQ-024 tx_credit_o SHALL equal the internal credit register.
REQ-025 Receiver: on an edge with rx_valid_i=1, rx_data_o <= rx_data_i and rx_count_o increments (wrapping at 2^32).
REQ-026 Receiver: rx_data_o SHALL hold its value when rx_valid_i=0.
REQ-027 rx_yummy_o SHALL be rx_valid_i registered once, so exactly one 1-cycle pulse follows each accepted word, one cycle later.
REQ-028 Back-to-back rx_valid_i SHALL produce back-to-back rx_yummy_o pulses.
REQ-029 No X SHALL propagate to any output after the first edge following reset release.

Reset
REQ-030 While rst_i=1, and immediately on its assertion, the block SHALL force these values independent of clk_i:
- credit = CREDITS, seq = 0
- tx_valid_o = 0, tx_data_o = {rank_i[15:0], dest_i[15:0], 32'h0}
- rx_data_o = 0, rx_count_o = 0, rx_yummy_o = 0
REQ-031 First edge after release SHALL set tx_valid_o=1 (CREDITS>=1); first transfer is seq 0 on the following edge.
REQ-032 Reset asserted mid-stream SHALL discard in-flight credits and pending yummy pulses.

Verification
REQ-033 rank=1, dest=2, CREDITS=4, tx_yummy_i=0 -> exactly 4 transfers, seq 0..3, data 0x0001_0002_0000_0000..03; then tx_valid_o=0 and tx_credit_o=0.
REQ-034 From the REQ-033 end state, pulse tx_yummy_i once -> tx_valid_o=1 for one cycle, word seq 4, credit returns to 0.
REQ-035 tx_yummy_i held at 1 continuously after reset -> tx_valid_o=1 every cycle, credit stays 4, seq increments each cycle.
REQ-036 tx_yummy_i pulsed with credit=4 and tx_valid_o=0 (forced by holding via reset release timing) -> credit stays 4.
REQ-037 rx_valid_i=1 for 3 cycles with data 0xA, 0xB, 0xC -> rx_data_o=0xC, rx_count_o=3, three rx_yummy_o pulses each one cycle later.
REQ-038 Assert rst_i mid-burst -> all outputs at reset values immediately, before the next clock edge.
